// File: rtl/disaster_alarm_ctrl.sv
// Hazard alarm controller: debounces four detector inputs, queues confirmed hazards and
// presents them one at a time by fixed priority. Optional escalation timer: ALARM_ESCALATE_EN.
module disaster_alarm_ctrl #(
   parameter int CONFIRM_CYCLES = 4,
   parameter int ACK_TIMEOUT    = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] det,
   input  logic       alarm_ack,
   output logic       alarm_valid,
   output logic [1:0] alarm_id,
   output logic [3:0] pending,
   output logic       escalate
);

   if (CONFIRM_CYCLES < 1 || CONFIRM_CYCLES > 15) begin : g_bad_confirm
      $error("CONFIRM_CYCLES must be 1..15");
   end
   if (ACK_TIMEOUT < 1 || ACK_TIMEOUT > 255) begin : g_bad_timeout
      $error("ACK_TIMEOUT must be 1..255");
   end

   localparam logic [3:0] CONF    = 4'(CONFIRM_CYCLES);
   localparam logic [3:0] CONF_M1 = 4'(CONFIRM_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, ALERT, GAP} state_t;

   state_t     state, state_nxt;
   logic [3:0] cnt [4];
   logic [3:0] conf_hit;
   logic [3:0] clr_mask;
   logic [1:0] first_id;
   logic       id_load;
   logic       ack_take;

   // Debounce: a counter only fires once per high run because it saturates at CONF
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (!det[i])
               cnt[i] <= '0;
            else if (cnt[i] != CONF)
               cnt[i] <= cnt[i] + 4'd1;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < 4; i++) conf_hit[i] = det[i] && (cnt[i] == CONF_M1);
   end

   always_comb begin
      first_id = 2'd0;
      if (pending[0])      first_id = 2'd0;
      else if (pending[1]) first_id = 2'd1;
      else if (pending[2]) first_id = 2'd2;
      else if (pending[3]) first_id = 2'd3;
   end

   assign ack_take = (state == ALERT) && alarm_ack;
   assign id_load  = (state == IDLE) && (pending != 4'b0000);
   assign clr_mask = ack_take ? (4'b0001 << alarm_id) : 4'b0000;

   // A confirmation landing on the same edge as the ack must survive, so set is ORed last
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending  <= 4'b0000;
         alarm_id <= 2'd0;
         state    <= IDLE;
      end else begin
         pending <= (pending & ~clr_mask) | conf_hit;
         if (id_load) alarm_id <= first_id;
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (id_load) state_nxt = ALERT;
         ALERT:   if (alarm_ack) state_nxt = GAP;
         GAP:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign alarm_valid = (state == ALERT);

`ifdef ALARM_ESCALATE_EN
   localparam logic [7:0] ACK_TO = 8'(ACK_TIMEOUT);

   logic [7:0] wait_cnt;

   // Wait counter saturates at ACK_TO so escalate holds until the ack arrives
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt <= 8'd0;
         escalate <= 1'b0;
      end else if (id_load) begin
         wait_cnt <= 8'd0;
      end else if (state == ALERT) begin
         if (alarm_ack) begin
            escalate <= 1'b0;
         end else if (wait_cnt != ACK_TO) begin
            wait_cnt <= wait_cnt + 8'd1;
            if ((wait_cnt + 8'd1) == ACK_TO) escalate <= 1'b1;
         end
      end
   end
`else
   assign escalate = 1'b0;
`endif

endmodule

// File: tb/tb_disaster_alarm_ctrl.sv
// Scoreboard bench for disaster_alarm_ctrl: expected alarm ids are queued as hazards are
// driven and popped when the controller presents an alarm.
module tb_disaster_alarm_ctrl;

   logic       clk;
   logic       rst;
   logic [3:0] det;
   logic       alarm_ack;
   logic       alarm_valid;
   logic [1:0] alarm_id;
   logic [3:0] pending;
   logic       escalate;

`ifdef ALARM_ESCALATE_EN
   localparam logic ESC_EN = 1'b1;
`else
   localparam logic ESC_EN = 1'b0;
`endif

   int n_chk = 0;
   int n_err = 0;
   int exp_q[$];
   logic prev_vld = 1'b0;

   disaster_alarm_ctrl #(.CONFIRM_CYCLES(4), .ACK_TIMEOUT(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .det        (det),
      .alarm_ack  (alarm_ack),
      .alarm_valid(alarm_valid),
      .alarm_id   (alarm_id),
      .pending    (pending),
      .escalate   (escalate)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic steps(input int n);
      for (int k = 0; k < n; k++) @(negedge clk);
   endtask

   // Each new alarm presentation must match the oldest queued expectation
   always @(negedge clk) begin
      if (rst) begin
         prev_vld = 1'b0;
      end else begin
         if (alarm_valid && !prev_vld) begin
            if (exp_q.size() == 0)
               chk("alarm_unexpected", {30'b0, alarm_id}, 32'hFFFF_FFFF);
            else
               chk("alarm_id", {30'b0, alarm_id}, exp_q.pop_front());
         end
         prev_vld = alarm_valid;
      end
   end

   initial begin
      int n_alarms;
      rst       = 1'b1;
      det       = 4'b0000;
      alarm_ack = 1'b0;
      steps(2);
      chk("rst_valid", alarm_valid, 0);
      chk("rst_pending", pending, 0);
      chk("rst_id", alarm_id, 0);
      chk("rst_esc", escalate, 0);
      rst = 1'b0;

      // Single flood hazard, full serve cycle
      det = 4'b0001;
      exp_q.push_back(0);
      steps(3);
      chk("flood_pend_e3", pending, 4'b0000);
      step();
      chk("flood_pend_e4", pending, 4'b0001);
      chk("flood_valid_e4", alarm_valid, 0);
      step();
      chk("flood_valid_e5", alarm_valid, 1);
      det = 4'b0000;
      alarm_ack = 1'b1;
      step();
      alarm_ack = 1'b0;
      chk("flood_pend_ack", pending, 4'b0000);
      chk("flood_gap", alarm_valid, 0);
      step();
      chk("flood_idle", alarm_valid, 0);
      chk("flood_id_hold", alarm_id, 0);

      // Short earthquake glitch never confirms
      det = 4'b0100;
      steps(3);
      det = 4'b0000;
      for (int k = 0; k < 4; k++) begin
         chk("glitch_pend", pending, 4'b0000);
         chk("glitch_valid", alarm_valid, 0);
         step();
      end

      // Cyclone and tsunami together; then flood arrives during tsunami (no preemption)
      det = 4'b1010;
      exp_q.push_back(1);
      exp_q.push_back(3);
      exp_q.push_back(0);
      steps(4);
      chk("dual_pend", pending, 4'b1010);
      step();
      chk("dual_valid1", alarm_valid, 1);
      steps(3);
      chk("dual_hold_id", alarm_id, 1);
      chk("dual_hold_pend", pending, 4'b1010);
      alarm_ack = 1'b1;
      step();
      alarm_ack = 1'b0;
      chk("dual_pend_ack1", pending, 4'b1000);
      chk("dual_gap", alarm_valid, 0);
      step();
      chk("dual_idle", alarm_valid, 0);
      step();
      chk("dual_valid2", alarm_valid, 1);
      chk("dual_id2", alarm_id, 3);
      det = 4'b1011;
      steps(4);
      chk("preempt_pend", pending, 4'b1001);
      chk("preempt_id", alarm_id, 3);
      chk("preempt_valid", alarm_valid, 1);
      det = 4'b0000;
      alarm_ack = 1'b1;
      step();
      alarm_ack = 1'b0;
      chk("preempt_pend_ack", pending, 4'b0001);
      steps(2);
      chk("flood2_valid", alarm_valid, 1);
      alarm_ack = 1'b1;
      step();
      alarm_ack = 1'b0;
      chk("flood2_pend_ack", pending, 4'b0000);
      steps(2);

      // Escalation timing, then a re-confirmation coinciding with the ack edge
      det = 4'b0001;
      exp_q.push_back(0);
      exp_q.push_back(0);
      steps(5);
      chk("esc_valid", alarm_valid, 1);
      det = 4'b0000;
      steps(15);
      chk("esc_e15", escalate, 0);
      step();
      chk("esc_e16", escalate, ESC_EN);
      steps(3);
      chk("esc_hold", escalate, ESC_EN);
      chk("esc_id", alarm_id, 0);
      det = 4'b0001;
      steps(3);
      alarm_ack = 1'b1;
      step();
      alarm_ack = 1'b0;
      det = 4'b0000;
      chk("setwins_pend", pending, 4'b0001);
      chk("esc_cleared", escalate, 0);
      chk("setwins_gap", alarm_valid, 0);
      step();
      chk("setwins_idle", alarm_valid, 0);
      step();
      chk("setwins_valid", alarm_valid, 1);
      alarm_ack = 1'b1;
      step();
      alarm_ack = 1'b0;
      chk("setwins_clear", pending, 4'b0000);
      steps(2);

      // Asynchronous reset in the middle of an alarm
      det = 4'b0010;
      exp_q.push_back(1);
      steps(5);
      chk("rstmid_valid", alarm_valid, 1);
      #2 rst = 1'b1;
      #1;
      chk("rstmid_async_valid", alarm_valid, 0);
      chk("rstmid_async_pend", pending, 4'b0000);
      chk("rstmid_async_esc", escalate, 0);
      #1 rst = 1'b0;
      exp_q.push_back(1);
      steps(3);
      chk("rstmid_pend_e3", pending, 4'b0000);
      chk("rstmid_valid_e3", alarm_valid, 0);
      step();
      chk("rstmid_pend_e4", pending, 4'b0010);
      step();
      chk("rstmid_revalid", alarm_valid, 1);
      det = 4'b0000;
      alarm_ack = 1'b1;
      step();
      alarm_ack = 1'b0;
      steps(2);

      // Long earthquake hold with prompt ack yields one alarm
      det = 4'b0100;
      exp_q.push_back(2);
      n_alarms = 0;
      for (int k = 0; k < 40; k++) begin
         alarm_ack = alarm_valid;
         if (alarm_valid) n_alarms++;
         step();
      end
      alarm_ack = 1'b0;
      det = 4'b0000;
      chk("long_alarms", n_alarms, 1);
      chk("long_pend", pending, 4'b0000);
      steps(3);

      chk("queue_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/disaster_alarm_ctrl.md
DISASTER_ALARM_CTRL -- requirements
Module: disaster_alarm_ctrl

Interface
REQ-001 Parameter CONFIRM_CYCLES, default 4, consecutive high samples needed to confirm a hazard; legal range 1..15.
REQ-002 Parameter ACK_TIMEOUT, default 16, cycles in ALERT before escalation; legal range 1..255.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset; asynchronous, active-high.
REQ-005 det  in  4  raw detector LEDs: bit0 flood, bit1 cyclone, bit2 earthquake, bit3 tsunami.
REQ-006 alarm_ack  in  1  annunciator accepts the current alarm.
REQ-007 alarm_valid  out  1  an alarm is being presented.
REQ-008 alarm_id  out  2  hazard index being presented; 0 flood, 1 cyclone, 2 earthquake, 3 tsunami.
REQ-009 pending  out  4  confirmed hazards not yet served; same bit order as det.
REQ-010 escalate  out  1  presented alarm not acknowledged within ACK_TIMEOUT cycles.

Function
REQ-011 Each hazard i SHALL have a 4-bit confirm counter: +1 per edge with det[i]=1, saturating at CONFIRM_CYCLES; cleared to 0 on any edge with det[i]=0.
REQ-012 pending[i] SHALL set on the edge where counter i goes from CONFIRM_CYCLES-1 to CONFIRM_CYCLES, so it is visible after the CONFIRM_CYCLES-th consecutive high sample.
REQ-013 A continuously high det[i] SHALL produce exactly one pending event; a new event requires det[i]=0 for at least one edge.
REQ-014 FSM states: IDLE, ALERT, GAP.
REQ-015 IDLE: if pending!=0, go to ALERT and latch alarm_id = lowest set index (flood > cyclone > earthquake > tsunami); otherwise stay.
REQ-016 ALERT: alarm_valid=1; alarm_id held stable; no preemption by newly pending higher-priority hazards.
REQ-017 ALERT with alarm_ack=1: clear pending[alarm_id] and go to GAP on that edge.
REQ-018 GAP: alarm_valid=0 for exactly one cycle, then go to IDLE.
REQ-019 alarm_ack in IDLE or GAP SHALL be ignored.
REQ-020 If a hazard's pending sets on the same edge its ack clears it, set wins and pending stays 1.
REQ-021 Latency: alarm_valid rises one cycle after pending first becomes nonzero while in IDLE.
REQ-022 alarm_id SHALL keep its last value outside ALERT.

Reset
REQ-023 While rst=1, asynchronously: state=IDLE, all counters=0, pending=0000, alarm_valid=0, alarm_id=00, escalate=0, timeout counter=0.
REQ-024 rst asserted mid-ALERT SHALL abort the alarm immediately; the event is not retained.

Configuration
REQ-025 Macro ALARM_ESCALATE_EN defined: an 8-bit wait counter clears on entry to ALERT and increments each ALERT cycle; escalate sets on the edge where it reaches ACK_TIMEOUT and clears on the edge alarm_ack is accepted.
REQ-026 escalate SHALL stay 1 until ack; counter saturates and does not wrap.
REQ-027 Macro undefined: no wait counter is implemented; escalate is constant 0; all other behaviour is identical.

Verification
REQ-028 det=0001 held 4 edges -> pending=0001 after edge 4; alarm_valid=1, alarm_id=0 one cycle later; ack -> pending=0000, valid=0 for one GAP cycle, then IDLE.
REQ-029 det[2]=1 for 3 edges then 0 -> pending stays 0000 and alarm_valid never asserts.
REQ-030 det=1010 rising together, held -> alarm_id=1 served first; after ack and GAP, alarm_id=3 presented.
REQ-031 ALARM_ESCALATE_EN, no ack -> escalate=1 after 16 ALERT cycles; ack clears escalate and pending bit. Without macro -> escalate=0 throughout.
REQ-032 rst pulse mid-ALERT, between clock edges -> alarm_valid=0, pending=0000 immediately; after release, no alarm until det reconfirms.
REQ-033 det=0100 held 40 cycles with prompt ack -> exactly one alarm presented (id=2).
